i2c_sensor_seq: RTL and testbench

I2C_SENSOR_SEQ -- requirements
Module: i2c_sensor_seq

---
 rtl/i2c_seq_pkg.sv | 33 +++
 rtl/i2c_seq_tick.sv | 36 +++
 rtl/i2c_sensor_seq.sv | 180 ++++++++++++++++++
 tb/tb_i2c_sensor_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// +--------------------------------------------------------------------+
// | i2c_seq_pkg : shared types and defaults for the I2C sensor sequencer |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

package i2c_seq_pkg;

  localparam int MAX_BURST = 16;
  localparam int MAX_INIT  = 8;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INIT_REQ  = 3'd1,
    S_INIT_WAIT = 3'd2,
    S_WAIT_TICK = 3'd3,
    S_RD_REQ    = 3'd4,
    S_RD_WAIT   = 3'd5,
    S_ERROR     = 3'd6
  } seq_state_t;

  // Table entry 0 lives in the least-significant byte.
  localparam logic [8*MAX_INIT-1:0] DEF_INIT_REG  = {40'h0, 8'h47, 8'h1C, 8'h6B};
  localparam logic [8*MAX_INIT-1:0] DEF_INIT_DATA = {40'h0, 8'h00, 8'h08, 8'h00};

  function automatic logic [7:0] byte_at(input logic [8*MAX_INIT-1:0] tbl,
                                         input logic [2:0] i);
    byte_at = tbl[8*i +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_seq_tick.sv
// +--------------------------------------------------------------------+
// | i2c_seq_tick : free-running 0..DIV-1 counter, tick on the wrap cycle |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module i2c_seq_tick #(
  parameter int DIV = 3000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Held at zero while stopped so the first wrap is a full period after run rises.
  always_ff @(posedge clk) begin
    if (!rst_n || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/i2c_sensor_seq.sv
// +--------------------------------------------------------------------+
// | i2c_sensor_seq : init-write then periodic burst-read I2C sequencer   |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module i2c_sensor_seq
  import i2c_seq_pkg::*;
#(
  parameter logic [6:0]              SLAVE_ADDR = 7'h68,
  parameter int                      N_INIT     = 3,
  parameter logic [7:0]              RD_REG     = 8'h3B,
  parameter int                      RD_LEN     = 14,
  parameter int                      SAMPLE_DIV = 3000,
  parameter int                      MAX_RETRY  = 3,
  parameter logic [8*MAX_INIT-1:0]   INIT_REG   = DEF_INIT_REG,
  parameter logic [8*MAX_INIT-1:0]   INIT_DATA  = DEF_INIT_DATA
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  output logic                   txn_req,
  output logic                   txn_rw,
  output logic [6:0]             txn_addr,
  output logic [7:0]             txn_reg,
  output logic [7:0]             txn_wdata,
  output logic [4:0]             txn_len,
  input  logic                   txn_done,
  input  logic                   txn_nack,
  input  logic [8*MAX_BURST-1:0] txn_rdata,
  output logic [8*RD_LEN-1:0]    sample,
  output logic                   sample_valid,
  output logic                   init_done,
  output logic                   error,
  output logic [7:0]             err_cnt
);

  seq_state_t            state, state_nxt;
  logic [2:0]            idx, idx_nxt;
  logic [7:0]            retry, retry_nxt;
  logic [7:0]            err_cnt_nxt;
  logic                  init_done_nxt;
  logic [8*RD_LEN-1:0]   sample_nxt;
  logic                  sample_valid_nxt;
  logic                  tick;
  logic                  rd_phase;
  logic                  unused_rdata;

  assign unused_rdata = ^txn_rdata;

  i2c_seq_tick #(.DIV(SAMPLE_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (init_done),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      idx          <= '0;
      retry        <= '0;
      err_cnt      <= '0;
      init_done    <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      retry        <= retry_nxt;
      err_cnt      <= err_cnt_nxt;
      init_done    <= init_done_nxt;
      sample       <= sample_nxt;
      sample_valid <= sample_valid_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx;
    retry_nxt        = retry;
    err_cnt_nxt      = err_cnt;
    init_done_nxt    = init_done;
    sample_nxt       = sample;
    sample_valid_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_INIT_REQ;
          idx_nxt   = '0;
          retry_nxt = '0;
        end
      end

      S_INIT_REQ: begin
        state_nxt = enable ? S_INIT_WAIT : S_IDLE;
      end

      S_INIT_WAIT: begin
        if (txn_done && txn_nack) begin
          err_cnt_nxt = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
          if (retry == 8'(MAX_RETRY)) begin
            state_nxt = S_ERROR;
          end else begin
            retry_nxt = retry + 8'd1;
            state_nxt = S_INIT_REQ;
          end
        end else if (txn_done) begin
          retry_nxt = '0;
          if (idx == 3'(N_INIT - 1)) begin
            idx_nxt       = '0;
            init_done_nxt = 1'b1;
            state_nxt     = S_WAIT_TICK;
          end else begin
            idx_nxt   = idx + 3'd1;
            state_nxt = S_INIT_REQ;
          end
        end
      end

      S_WAIT_TICK: begin
        if (!enable) begin
          init_done_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end else if (tick) begin
          state_nxt = S_RD_REQ;
        end
      end

      S_RD_REQ: begin
        if (!enable) begin
          init_done_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end else begin
          state_nxt = S_RD_WAIT;
        end
      end

      // Ticks arriving here are ignored: a late reader skips that period.
      S_RD_WAIT: begin
        if (txn_done && txn_nack) begin
          err_cnt_nxt = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
          if (retry == 8'(MAX_RETRY)) begin
            state_nxt = S_ERROR;
          end else begin
            retry_nxt = retry + 8'd1;
            state_nxt = S_RD_REQ;
          end
        end else if (txn_done) begin
          retry_nxt        = '0;
          sample_nxt       = txn_rdata[8*RD_LEN-1:0];
          sample_valid_nxt = 1'b1;
          state_nxt        = S_WAIT_TICK;
        end
      end

      S_ERROR: begin
        state_nxt = S_ERROR;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Request is high only in the WAIT states, so every REQ state forms the one-cycle gap.
  assign rd_phase  = (state == S_RD_REQ) || (state == S_RD_WAIT);
  assign txn_req   = (state == S_INIT_WAIT) || (state == S_RD_WAIT);
  assign txn_rw    = rd_phase;
  assign txn_addr  = SLAVE_ADDR;
  assign txn_reg   = rd_phase ? RD_REG : byte_at(INIT_REG, idx);
  assign txn_wdata = rd_phase ? 8'h00  : byte_at(INIT_DATA, idx);
  assign txn_len   = rd_phase ? 5'(RD_LEN) : 5'd1;
  assign error     = (state == S_ERROR);

endmodule

`default_nettype wire

// File: tb/tb_i2c_sensor_seq.sv
// +--------------------------------------------------------------------+
// | tb_i2c_sensor_seq : scoreboard bench with a scripted I2C slave model |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_i2c_sensor_seq;

  localparam int DIV = 64;
  localparam int LEN = 14;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             txn_req, txn_rw;
  logic [6:0]       txn_addr;
  logic [7:0]       txn_reg, txn_wdata, err_cnt;
  logic [4:0]       txn_len;
  logic             txn_done, txn_nack;
  logic [127:0]     txn_rdata;
  logic [8*LEN-1:0] sample;
  logic             sample_valid, init_done, error;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_rd = -1;
  int exp_gap = 0;
  int read_delay = 2;
  bit nack_all = 1'b0;
  bit spurious = 1'b0;
  bit prev_req = 1'b0;
  bit done_q = 1'b0;
  logic [7:0] rd_base = 8'h00;

  logic [28:0]      exp_txn[$];
  logic [8*LEN-1:0] exp_smp[$];
  bit               nack_plan[$];

  i2c_sensor_seq #(.SAMPLE_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .txn_req(txn_req), .txn_rw(txn_rw), .txn_addr(txn_addr), .txn_reg(txn_reg),
    .txn_wdata(txn_wdata), .txn_len(txn_len), .txn_done(txn_done), .txn_nack(txn_nack),
    .txn_rdata(txn_rdata), .sample(sample), .sample_valid(sample_valid),
    .init_done(init_done), .error(error), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cycle  <= cycle + 1;
    done_q <= txn_done;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [28:0] wr_t(input logic [7:0] r, input logic [7:0] d);
    return {1'b0, 7'h68, r, d, 5'd1};
  endfunction

  function automatic logic [28:0] rd_t();
    return {1'b1, 7'h68, 8'h3B, 8'h00, 5'd14};
  endfunction

  function automatic logic [8*LEN-1:0] smp(input logic [7:0] base);
    logic [8*LEN-1:0] s;
    for (int i = 0; i < LEN; i++) s[8*i +: 8] = base + 8'(i);
    return s;
  endfunction

  task automatic push_init();
    exp_txn.push_back(wr_t(8'h6B, 8'h00));
    exp_txn.push_back(wr_t(8'h1C, 8'h08));
    exp_txn.push_back(wr_t(8'h47, 8'h00));
  endtask

  task automatic do_reset(input string tag);
    enable = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    check({tag, "_rst_req"},   txn_req, 0);
    check({tag, "_rst_smp"},   sample, 0);
    check({tag, "_rst_sv"},    sample_valid, 0);
    check({tag, "_rst_init"},  init_done, 0);
    check({tag, "_rst_err"},   error, 0);
    check({tag, "_rst_cnt"},   err_cnt, 0);
    rst_n   = 1'b1;
    last_rd = -1;
    @(negedge clk);
  endtask

  task automatic wait_queues(input string name, input int maxc);
    int n = 0;
    while ((exp_txn.size() != 0 || exp_smp.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (exp_txn.size() != 0 || exp_smp.size() != 0) timeout(name);
  endtask

  task automatic wait_flag(input string name, input int which, input int maxc);
    int n = 0;
    while (n < maxc && !((which == 0 && init_done) || (which == 1 && error) ||
                         (which == 2 && txn_req && txn_rw))) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxc) timeout(name);
  endtask

  // Slave model: answers each request after a delay, abandons it if the request drops.
  initial begin : slave
    txn_done = 1'b0; txn_nack = 1'b0; txn_rdata = '0;
    forever begin
      @(negedge clk);
      if (spurious) begin
        txn_done = 1'b1; txn_nack = 1'b1;
        @(negedge clk);
        txn_done = 1'b0; txn_nack = 1'b0; spurious = 1'b0;
      end else if (txn_req) begin
        int d;
        int i;
        bit abort;
        bit nk;
        d = txn_rw ? read_delay : 2;
        abort = 1'b0;
        i = 0;
        while (i < d && !abort) begin
          @(negedge clk);
          if (!txn_req) abort = 1'b1;
          i++;
        end
        if (!abort) begin
          nk = nack_all;
          if (nack_plan.size() != 0) nk = nack_plan.pop_front();
          for (int b = 0; b < 16; b++) txn_rdata[8*b +: 8] = rd_base + 8'(b);
          txn_done = 1'b1; txn_nack = nk;
          @(negedge clk);
          txn_done = 1'b0; txn_nack = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (done_q) check("req_gap", txn_req, 0);
      if (txn_req && !prev_req) begin
        if (exp_txn.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_txn: got %0h expected none",
                   {txn_rw, txn_addr, txn_reg, txn_wdata, txn_len});
        end else begin
          check("txn", {txn_rw, txn_addr, txn_reg, txn_wdata, txn_len}, exp_txn.pop_front());
        end
        if (txn_rw) begin
          if (last_rd >= 0 && exp_gap > 0) check("rd_gap", cycle - last_rd, exp_gap);
          last_rd = cycle;
        end
      end
      if (sample_valid) begin
        if (exp_smp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0h expected none", sample);
        end else begin
          check("sample", sample, exp_smp.pop_front());
        end
      end
      prev_req = txn_req;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Init writes then three periodic reads spaced DIV apart.
    do_reset("t1");
    exp_gap = DIV; rd_base = 8'h00; read_delay = 2;
    push_init();
    for (int k = 0; k < 3; k++) begin
      exp_txn.push_back(rd_t());
      exp_smp.push_back(smp(8'h00));
    end
    enable = 1'b1;
    wait_flag("t1_init", 0, 100);
    check("t1_init_done", init_done, 1);
    wait_queues("t1_reads", 400);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_disable", init_done, 0);

    // Second write NACKed twice.
    do_reset("t2");
    exp_gap = 0;
    nack_plan.push_back(1'b0); nack_plan.push_back(1'b1); nack_plan.push_back(1'b1);
    exp_txn.push_back(wr_t(8'h6B, 8'h00));
    for (int k = 0; k < 3; k++) exp_txn.push_back(wr_t(8'h1C, 8'h08));
    exp_txn.push_back(wr_t(8'h47, 8'h00));
    enable = 1'b1;
    wait_flag("t2_init", 0, 150);
    check("t2_err_cnt", err_cnt, 2);
    check("t2_error", error, 0);
    check("t2_init_done", init_done, 1);
    check("t2_queue", exp_txn.size(), 0);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Every attempt NACKed: four tries then a locked error state.
    do_reset("t3");
    nack_all = 1'b1;
    for (int k = 0; k < 4; k++) exp_txn.push_back(wr_t(8'h6B, 8'h00));
    enable = 1'b1;
    wait_flag("t3_error", 1, 150);
    check("t3_err_cnt", err_cnt, 4);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("t3_error_hold", error, 1);
    check("t3_req_low", txn_req, 0);
    check("t3_queue", exp_txn.size(), 0);
    nack_all = 1'b0;

    // Slow reader: the wrap during the long read is dropped.
    do_reset("t4");
    exp_gap = 2 * DIV; read_delay = DIV + 10; rd_base = 8'h20;
    push_init();
    for (int k = 0; k < 2; k++) begin
      exp_txn.push_back(rd_t());
      exp_smp.push_back(smp(8'h20));
    end
    enable = 1'b1;
    wait_queues("t4_reads", 600);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    // Reset during an outstanding read, stray done in IDLE, then a fresh init.
    do_reset("t5");
    exp_gap = 0; read_delay = 2; rd_base = 8'h40;
    push_init();
    exp_txn.push_back(rd_t());
    exp_smp.push_back(smp(8'h40));
    enable = 1'b1;
    wait_queues("t5_first", 300);
    read_delay = 1000;
    exp_txn.push_back(rd_t());
    wait_flag("t5_rd_wait", 2, 150);
    repeat (5) @(negedge clk);
    do_reset("t5b");
    spurious = 1'b1;
    repeat (4) @(negedge clk);
    check("t5_stray_req", txn_req, 0);
    check("t5_stray_cnt", err_cnt, 0);
    check("t5_stray_init", init_done, 0);
    read_delay = 2;
    push_init();
    enable = 1'b1;
    wait_flag("t5_reinit", 0, 100);
    check("t5_queue", exp_txn.size(), 0);
    enable = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
